// File: rtl/rf_write_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module : rf_write_port_ctrl
// Purpose: Owns the single write port of the register file. It merges the
//          in-order pipeline writeback, which has absolute priority, with
//          long-latency results queued in a small FIFO. The FIFO drains into
//          any write slot the pipeline leaves free. A per-register busy mask
//          is exported to the hazard unit.
// Ports  : clk, rst (sync, active-low)
//          wb_valid/wb_rd/wb_data     - pipeline writeback request
//          lu_valid/lu_ready/lu_rd/lu_data - long-latency push handshake
//          rf_write/rf_waddr/rf_wdata - register file write port (registered)
//          busy_mask                  - bit r = a live queued entry targets xr
//          q_count/q_full/q_empty     - FIFO occupancy (live + dead entries)
// Rev    : 1.0 - initial release
// ============================================================================
module rf_write_port_ctrl #(
  parameter int n     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_valid,
  input  logic [4:0]                 wb_rd,
  input  logic [n-1:0]               wb_data,
  input  logic                       lu_valid,
  output logic                       lu_ready,
  input  logic [4:0]                 lu_rd,
  input  logic [n-1:0]               lu_data,
  output logic                       rf_write,
  output logic [4:0]                 rf_waddr,
  output logic [n-1:0]               rf_wdata,
  output logic [31:0]                busy_mask,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic                       q_full,
  output logic                       q_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // FIFO storage. The live bit marks entries still destined for the
  // register file; dead entries only occupy a slot until popped.
  logic [4:0]       rd_q   [DEPTH];
  logic [n-1:0]     data_q [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [31:0]      busy_q, busy_d;

  logic             rf_write_q, rf_write_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [n-1:0]     rf_wdata_q, rf_wdata_d;

  logic             w_p1;
  logic             w_pop;
  logic             w_push;
  logic             w_push_live;

  assign q_full    = (count_q == CW'(DEPTH));
  assign q_empty   = (count_q == '0);
  // Ready looks only at the registered count, so a same-cycle pop never
  // creates room for a push.
  assign lu_ready  = !q_full;
  assign q_count   = count_q;
  assign busy_mask = busy_q;
  assign rf_write  = rf_write_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;

  assign w_p1   = wb_valid && (wb_rd != 5'd0);
  assign w_pop  = !w_p1 && !q_empty;
  assign w_push = lu_valid && lu_ready;
  // An incoming entry is dead on arrival if it targets x0 or if the pipeline
  // is writing the same register in this very cycle (pipeline value is newer).
  assign w_push_live = (lu_rd != 5'd0) && !(w_p1 && (lu_rd == wb_rd));

  // Next-state for live bits, pointers, count and busy mask.
  always_comb begin
    live_d  = live_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    busy_d  = '0;

    // Kill every queued entry overwritten by the pipeline write.
    if (w_p1) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (live_q[i] && (rd_q[i] == wb_rd)) begin
          live_d[i] = 1'b0;
        end
      end
    end

    if (w_pop) begin
      live_d[rptr_q] = 1'b0;
      rptr_d         = rptr_q + AW'(1);
    end

    if (w_push) begin
      live_d[wptr_q] = w_push_live;
      wptr_d         = wptr_q + AW'(1);
    end

    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Busy mask built from the post-update entry set; the slot being pushed
    // takes its new destination, every other slot keeps its stored one.
    for (int i = 0; i < DEPTH; i++) begin
      if (live_d[i]) begin
        if (w_push && (AW'(i) == wptr_q)) begin
          busy_d[lu_rd] = 1'b1;
        end else begin
          busy_d[rd_q[i]] = 1'b1;
        end
      end
    end
    busy_d[0] = 1'b0;
  end

  // Write-slot arbitration: pipeline first, then the FIFO head.
  always_comb begin
    rf_write_d = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (w_p1) begin
      rf_write_d = 1'b1;
      rf_waddr_d = wb_rd;
      rf_wdata_d = wb_data;
    end else if (w_pop && live_q[rptr_q]) begin
      rf_write_d = 1'b1;
      rf_waddr_d = rd_q[rptr_q];
      rf_wdata_d = data_q[rptr_q];
    end
    // A dead head still consumes the slot but produces no write and leaves
    // the address/data outputs untouched.
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      live_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      busy_q     <= '0;
      rf_write_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      live_q     <= live_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      rf_write_q <= rf_write_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Payload storage needs no reset: contents are only observed through
  // live bits, which are cleared on reset.
  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      rd_q[wptr_q]   <= lu_rd;
      data_q[wptr_q] <= lu_data;
    end
  end

endmodule
`default_nettype wire
